// File: rtl/alu_compare_pipe.sv
// -----------------------------------------------------------------------------
// alu_compare_pipe
//
// Pipelined magnitude comparator for the RV32IM ALU/branch path. Each operation
// compares op_a against op_b (signed or unsigned, chosen by funct3). It returns
// eq/lt/gt, the branch-taken / SLT(U) condition bit, min/max and the sideband
// tag. The result appears STAGES cycles after acceptance when the pipeline is
// not stalled.
//
// Ports
//   clk, rst_n      rising-edge clock, synchronous active-low reset
//   flush           kills every in-flight operation (and any input this cycle)
//   in_valid/ready  input handshake; in_ready is combinational from out_ready
//   op_a, op_b      operands (rs1, rs2/imm)
//   funct3          compare mode (BEQ/BNE/SLT/SLTU/BLT/BGE/BLTU/BGEU)
//   in_tag          sideband carried unchanged to out_tag
//   out_valid/ready output handshake
//   eq, lt, gt      relation of a to b in the selected signedness
//   cond            branch-taken or SLT(U) result bit
//   res_min/res_max min/max of the operands in the selected signedness
//   out_tag         tag of the operation on the outputs
//
// While out_valid is low, every result output is driven to zero.
// -----------------------------------------------------------------------------
module alu_compare_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int STAGES     = 2,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    input  logic [2:0]            funct3,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  eq,
    output logic                  lt,
    output logic                  gt,
    output logic                  cond,
    output logic [DATA_WIDTH-1:0] res_min,
    output logic [DATA_WIDTH-1:0] res_max,
    output logic [TAG_WIDTH-1:0]  out_tag
);

    // Payload layout: {tag, max, min, cond, gt, lt, eq}
    localparam int PW = 4 + 2 * DATA_WIDTH + TAG_WIDTH;

    // ------------------------------------------------------------------
    // Compare logic, evaluated on the incoming operands
    // ------------------------------------------------------------------
    logic                  is_unsigned;
    logic [DATA_WIDTH:0]   ext_a;
    logic [DATA_WIDTH:0]   ext_b;
    logic [DATA_WIDTH:0]   diff;
    logic                  cmp_eq;
    logic                  cmp_lt;
    logic                  cmp_gt;
    logic                  cmp_cond;
    logic [DATA_WIDTH-1:0] cmp_min;
    logic [DATA_WIDTH-1:0] cmp_max;
    logic [PW-1:0]         in_pay;

    // SLTU (011), BLTU (110) and BGEU (111) are the unsigned modes.
    assign is_unsigned = (funct3 == 3'b011) | (funct3[2:1] == 2'b11);

    always_comb begin
        // One extra bit of extension keeps the difference free of overflow,
        // so its top bit is the true "a < b" in either signedness.
        ext_a    = {(is_unsigned ? 1'b0 : op_a[DATA_WIDTH-1]), op_a};
        ext_b    = {(is_unsigned ? 1'b0 : op_b[DATA_WIDTH-1]), op_b};
        diff     = ext_a - ext_b;
        cmp_lt   = diff[DATA_WIDTH];
        cmp_eq   = (diff == '0);
        cmp_gt   = ~cmp_lt & ~cmp_eq;
        cmp_min  = cmp_lt ? op_a : op_b;
        cmp_max  = cmp_lt ? op_b : op_a;
        cmp_cond = 1'b0;
        case (funct3)
            3'b000:  cmp_cond = cmp_eq;    // BEQ
            3'b001:  cmp_cond = ~cmp_eq;   // BNE
            3'b101:  cmp_cond = ~cmp_lt;   // BGE
            3'b111:  cmp_cond = ~cmp_lt;   // BGEU
            default: cmp_cond = cmp_lt;    // SLT, SLTU, BLT, BLTU
        endcase
        in_pay = {in_tag, cmp_max, cmp_min, cmp_cond, cmp_gt, cmp_lt, cmp_eq};
    end

    // ------------------------------------------------------------------
    // Pipeline: pipe_*[0] is the input side, pipe_*[k+1] is stage k.
    // rdy[k] means stage k may load this cycle; an empty stage is always
    // ready, so bubbles collapse behind a stalled output.
    // ------------------------------------------------------------------
    logic            pipe_v   [STAGES+1];
    logic [PW-1:0]   pipe_pay [STAGES+1];
    logic [STAGES:0] rdy;

    assign pipe_v[0]   = in_valid;
    assign pipe_pay[0] = in_pay;
    assign rdy[STAGES] = out_ready;
    assign in_ready    = rdy[0];

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            logic          v_q;
            logic          v_d;
            logic [PW-1:0] pay_q;
            logic [PW-1:0] pay_d;

            assign rdy[gi] = ~v_q | rdy[gi+1];

            always_comb begin
                v_d   = v_q;
                pay_d = pay_q;
                if (rdy[gi]) begin
                    v_d   = pipe_v[gi];
                    pay_d = pipe_pay[gi];
                end
                // Flush also drops whatever is being accepted this cycle.
                if (flush) begin
                    v_d = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    v_q   <= 1'b0;
                    pay_q <= '0;
                end else begin
                    v_q   <= v_d;
                    pay_q <= pay_d;
                end
            end

            assign pipe_v[gi+1]   = v_q;
            assign pipe_pay[gi+1] = pay_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs: last stage, zeroed whenever it holds no valid result
    // ------------------------------------------------------------------
    logic [PW-1:0] out_pay;

    assign out_valid = pipe_v[STAGES];

    always_comb begin
        out_pay = out_valid ? pipe_pay[STAGES] : '0;
    end

    assign {out_tag, res_max, res_min, cond, gt, lt, eq} = out_pay;

endmodule

// File: tb/tb_alu_compare_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_compare_pipe
//
// Self-checking bench for alu_compare_pipe (DATA_WIDTH=32, STAGES=2,
// TAG_WIDTH=5). Inputs change 1 time unit after the rising edge and outputs
// are sampled on the falling edge. Accepted operations are pushed into an
// expected-result queue computed by a plain-arithmetic reference model and
// popped on every output transfer.
// -----------------------------------------------------------------------------
module tb_alu_compare_pipe;

    localparam int DW  = 32;
    localparam int ST  = 2;
    localparam int TW  = 5;

    typedef struct packed {
        logic          eq;
        logic          lt;
        logic          gt;
        logic          cond;
        logic [DW-1:0] mn;
        logic [DW-1:0] mx;
        logic [TW-1:0] tag;
    } res_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic [2:0]    funct3;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic          eq;
    logic          lt;
    logic          gt;
    logic          cond;
    logic [DW-1:0] res_min;
    logic [DW-1:0] res_max;
    logic [TW-1:0] out_tag;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   tick_idx;
    logic obs_in_ready;
    logic obs_out_valid;
    res_t exp_q[$];

    alu_compare_pipe #(
        .DATA_WIDTH (DW),
        .STAGES     (ST),
        .TAG_WIDTH  (TW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .funct3    (funct3),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .eq        (eq),
        .lt        (lt),
        .gt        (gt),
        .cond      (cond),
        .res_min   (res_min),
        .res_max   (res_max),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    // Reference model: straight from the mode table, using the language's
    // own signed/unsigned comparison operators.
    function automatic res_t model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                   input logic [2:0] f3, input logic [TW-1:0] tag);
        res_t r;
        bit   uns;
        uns    = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        r.lt   = uns ? (a < b) : ($signed(a) < $signed(b));
        r.eq   = (a == b);
        r.gt   = !r.lt && !r.eq;
        case (f3)
            3'd0:       r.cond = r.eq;
            3'd1:       r.cond = !r.eq;
            3'd5, 3'd7: r.cond = !r.lt;
            default:    r.cond = r.lt;
        endcase
        r.mn  = r.lt ? a : b;
        r.mx  = r.lt ? b : a;
        r.tag = tag;
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'($urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    // Advance one cycle: sample outputs at the falling edge, update the
    // expected queue from the handshakes, then return 1 unit after the edge.
    task automatic tick(output bit xfer, output bit have_exp,
                        output res_t got, output res_t expv);
        @(negedge clk);
        tick_idx      = cyc;
        obs_in_ready  = in_ready;
        obs_out_valid = out_valid;
        got           = {eq, lt, gt, cond, res_min, res_max, out_tag};
        xfer          = rst_n && out_valid && out_ready;
        have_exp      = 1'b0;
        expv          = '0;
        if (xfer) begin
            $display("xfer tag=%0d eq=%b lt=%b gt=%b cond=%b min=%h max=%h",
                     out_tag, eq, lt, gt, cond, res_min, res_max);
            if (exp_q.size() > 0) begin
                expv     = exp_q.pop_front();
                have_exp = 1'b1;
            end
        end
        if (rst_n && !flush && in_valid && in_ready)
            exp_q.push_back(model(op_a, op_b, funct3, in_tag));
        if (!rst_n || flush)
            exp_q.delete();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [2:0] f3, input logic [TW-1:0] tag);
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        funct3   = f3;
        in_tag   = tag;
    endtask

    task automatic test_reset();
        bit   x, h;
        res_t g, e;
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive_op(32'h5, 32'h3, 3'd4, 5'd9);
        for (int i = 0; i < 3; i++) tick(x, h, g, e);
        checks++;
        if (obs_out_valid !== 1'b0 || g !== '0) begin
            errors++;
            $display("FAIL reset_outputs got valid=%b res=%h required valid=0 res=0", obs_out_valid, g);
        end
        rst_n = 1'b1; in_valid = 1'b0;
        tick(x, h, g, e);
        checks++;
        if (obs_in_ready !== 1'b1 || obs_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got in_ready=%b out_valid=%b required 1/0", obs_in_ready, obs_out_valid);
        end
    endtask

    task automatic test_directed();
        logic [DW-1:0] ta [9] = '{32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                                  32'h1234, 32'h1234, 32'h1234, 32'h5, 32'h1};
        logic [DW-1:0] tb [9] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                  32'h1234, 32'h1234, 32'h1234, 32'h3, 32'h2};
        logic [2:0]    tf [9] = '{3'd4, 3'd6, 3'd2, 3'd3, 3'd0, 3'd1, 3'd5, 3'd7, 3'd1};
        logic          tl [9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic          tc [9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        bit   x, h, done;
        res_t g, e;
        int   acc;
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive_op(ta[i], tb[i], tf[i], TW'(i));
            tick(x, h, g, e);
            acc = tick_idx;
            in_valid = 1'b0;
            done = 1'b0;
            for (int w = 0; w < 10 && !done; w++) begin
                tick(x, h, g, e);
                if (x) begin
                    done = 1'b1;
                    checks++;
                    if (!h || g !== e) begin
                        errors++;
                        $display("FAIL directed_%0d got=%h required=%h", i, g, e);
                    end
                    checks++;
                    if (g.lt !== tl[i] || g.cond !== tc[i]) begin
                        errors++;
                        $display("FAIL directed_bits_%0d got lt=%b cond=%b required lt=%b cond=%b",
                                 i, g.lt, g.cond, tl[i], tc[i]);
                    end
                    checks++;
                    if (tick_idx - acc != ST) begin
                        errors++;
                        $display("FAIL directed_latency_%0d got=%0d required=%0d", i, tick_idx - acc, ST);
                    end
                end
            end
            if (!done) begin
                checks++; errors++;
                $display("FAIL directed_timeout_%0d got no result required one", i);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit   x, h;
        res_t g, e;
        int   first_acc = 0;
        int   n = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (i < 8) drive_op(rand_operand(), rand_operand(), 3'($urandom), TW'(i));
            else       in_valid = 1'b0;
            tick(x, h, g, e);
            if (i == 0) first_acc = tick_idx;
            if (i < 8) begin
                checks++;
                if (obs_in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_in_ready_%0d got=%b required=1", i, obs_in_ready);
                end
            end
            if (x) begin
                checks++;
                if (!h || g !== e || g.tag !== TW'(n) || tick_idx != first_acc + ST + n) begin
                    errors++;
                    $display("FAIL b2b_result_%0d got=%h at cycle %0d required=%h tag %0d at cycle %0d",
                             n, g, tick_idx, e, n, first_acc + ST + n);
                end
                n++;
            end
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL b2b_count got=%0d required=8", n);
        end
    endtask

    task automatic test_stall();
        bit   x, h;
        res_t g, e, prev;
        int   tag = 0;
        prev = '0;
        out_ready = 1'b1;
        drive_op(rand_operand(), rand_operand(), 3'($urandom), TW'(tag));
        for (int i = 0; i < 40; i++) begin
            out_ready = !(i >= 6 && i < 11);
            if (i >= 20) in_valid = 1'b0;
            tick(x, h, g, e);
            if (in_valid && obs_in_ready) begin
                tag++;
                if (i < 19) drive_op(rand_operand(), rand_operand(), 3'($urandom), TW'(tag));
            end
            if (i > 6 && i < 11) begin
                checks++;
                if (obs_out_valid !== 1'b1 || g !== prev) begin
                    errors++;
                    $display("FAIL stall_stable_%0d got=%h valid=%b required=%h valid=1", i, g, obs_out_valid, prev);
                end
            end
            if (i == 10) begin
                checks++;
                if (obs_in_ready !== 1'b0 || exp_q.size() != ST) begin
                    errors++;
                    $display("FAIL stall_full got in_ready=%b queued=%0d required in_ready=0 queued=%0d",
                             obs_in_ready, exp_q.size(), ST);
                end
            end
            prev = g;
            if (x) begin
                checks++;
                if (!h || g !== e) begin
                    errors++;
                    $display("FAIL stall_result got=%h required=%h", g, e);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_drain got %0d outstanding required 0", exp_q.size());
        end
    endtask

    task automatic test_random();
        bit   x, h;
        res_t g, e;
        for (int i = 0; i < 520; i++) begin
            if (i < 500) begin
                if ($urandom_range(0, 3) != 0)
                    drive_op(rand_operand(), rand_operand(), 3'($urandom), TW'($urandom));
                else
                    in_valid = 1'b0;
                out_ready = ($urandom_range(0, 2) != 0);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            tick(x, h, g, e);
            if (x) begin
                checks++;
                if (!h || g !== e || (g.eq + g.lt + g.gt) != 1) begin
                    errors++;
                    $display("FAIL random_result got=%h required=%h", g, e);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_drain got %0d outstanding required 0", exp_q.size());
        end
    endtask

    task automatic test_flush();
        bit   x, h;
        res_t g, e;
        out_ready = 1'b0;
        drive_op(32'h10, 32'h20, 3'd4, 5'd1);
        tick(x, h, g, e);
        drive_op(32'h30, 32'h20, 3'd4, 5'd2);
        tick(x, h, g, e);
        drive_op(32'h40, 32'h40, 3'd0, 5'd3);
        flush = 1'b1;
        tick(x, h, g, e);
        checks++;
        if (obs_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_setup got out_valid=%b required=1", obs_out_valid);
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick(x, h, g, e);
        checks++;
        if (obs_out_valid !== 1'b0 || obs_in_ready !== 1'b1 || g !== '0) begin
            errors++;
            $display("FAIL flush_next got valid=%b in_ready=%b res=%h required 0/1/0",
                     obs_out_valid, obs_in_ready, g);
        end
        for (int i = 0; i < 8; i++) begin
            tick(x, h, g, e);
            checks++;
            if (obs_out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_leak got out_valid=1 tag=%0d required 0", g.tag);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit   x, h;
        res_t g, e;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_op(rand_operand(), rand_operand(), 3'($urandom), TW'(i + 20));
            tick(x, h, g, e);
            if (x) begin
                checks++;
                if (!h || g !== e) begin
                    errors++;
                    $display("FAIL rstmid_result got=%h required=%h", g, e);
                end
            end
        end
        out_ready = 1'b0;
        rst_n = 1'b0;
        tick(x, h, g, e);
        tick(x, h, g, e);
        checks++;
        if (obs_out_valid !== 1'b0 || g !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs got valid=%b res=%h required 0/0", obs_out_valid, g);
        end
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(x, h, g, e);
            checks++;
            if (obs_out_valid !== 1'b0 || obs_in_ready !== 1'b1) begin
                errors++;
                $display("FAIL rstmid_after got valid=%b in_ready=%b required 0/1", obs_out_valid, obs_in_ready);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; funct3 = '0; in_tag = '0;
        tick_idx = 0; obs_in_ready = 1'b0; obs_out_valid = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_random();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
